// File: rtl/bitstream_byte_fetch_pkg.sv
// Shared constants and types for the slice-data byte feeder of the
// bypass-bin / arithmetic decoder datapath.
package bitstream_byte_fetch_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

    // Byte delivered to the decoder once the slice data is exhausted.
    localparam logic [BYTE_W-1:0] STUFF_BYTE = 8'h00;

    // Slice-stream word handshake as seen on the input side.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              valid;
        logic              last;
        logic [2:0]        nbytes;
    } slice_word_t;

    // Number of bytes a word contributes: only a final word may be short,
    // and an out-of-range count on a final word falls back to a full word.
    function automatic logic [2:0] word_push_count(input logic last,
                                                   input logic [2:0] nbytes);
        if (last && (nbytes != 3'd0) && (nbytes <= 3'd4)) begin
            return nbytes;
        end
        return 3'd4;
    endfunction

endpackage

// File: rtl/bitstream_byte_fetch_byte_fifo.sv
// Byte FIFO with up-to-4-byte push (MSB byte first) and single-byte pop.
// Pointers carry a wrap bit so occupancy is a plain pointer difference.
module byte_fifo
    import bitstream_byte_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [2:0]        push_n_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] head_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_next_o,
    output logic [LVL_W-1:0]  free_next_o
);

    localparam int unsigned AW = LVL_W - 1;

    logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_idx [WORD_BYTES];
    logic              empty;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign empty_o = empty;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers, write slot addresses and next-state occupancy/free space.
    always_comb begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            wr_idx[i] = wr_ptr_q[AW-1:0] + AW'(i);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + LVL_W'(push_n_i);
            rd_ptr_d = rd_ptr_q + LVL_W'(pop_i && !empty);
        end
        level_next_o = wr_ptr_d - rd_ptr_d;
        free_next_o  = LVL_W'(DEPTH) - level_next_o;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Byte storage: byte i of the push comes from word lane [31-8i -: 8].
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (!flush_i && (3'(i) < push_n_i)) begin
                mem_q[wr_idx[i]] <= push_data_i[BYTE_W*(WORD_BYTES-1-i) +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/bitstream_byte_fetch.sv
// Slice-data byte feeder: unpacks 32-bit stream words into a byte FIFO and
// serves one byte per decoder request, stuffing 0x00 past end of slice.
module bitstream_byte_fetch
    import bitstream_byte_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    input  logic              word_last_i,
    input  logic [2:0]        word_nbytes_i,
    output logic              word_ready_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_req_i,
    output logic [CNT_W-1:0]  byte_count_o,
    output logic              eos_o,
    output logic [CNT_W-1:0]  overrun_count_o
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    slice_word_t       w;
    logic              word_ready_q, word_ready_d;
    logic              last_seen_q, last_seen_d;
    logic              eos_q, eos_d;
    logic [CNT_W-1:0]  byte_count_q, byte_count_d;
    logic [CNT_W-1:0]  overrun_q, overrun_d;
    logic              push, pop_real;
    logic [2:0]        push_n;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_empty;
    logic [LVL_W-1:0]  level_next, free_next;

    assign w = '{data: word_i, valid: word_valid_i, last: word_last_i, nbytes: word_nbytes_i};

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (start_i),
        .push_n_i     (push_n),
        .push_data_i  (w.data),
        .pop_i        (pop_real),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .level_next_o (level_next),
        .free_next_o  (free_next)
    );

    // Outputs are decoded from registered state only; start masks the
    // registered ready so no word is taken in the flush cycle.
    assign word_ready_o    = word_ready_q && !start_i;
    assign byte_valid_o    = eos_q || !fifo_empty;
    assign byte_o          = (eos_q || fifo_empty) ? STUFF_BYTE : fifo_head;
    assign byte_count_o    = byte_count_q;
    assign eos_o           = eos_q;
    assign overrun_count_o = overrun_q;

    // Handshakes, end-of-stream tracking and counter next-state.
    always_comb begin
        push     = w.valid && word_ready_q && !start_i;
        push_n   = push ? word_push_count(w.last, w.nbytes) : 3'd0;
        pop_real = byte_req_i && !fifo_empty && !eos_q && !start_i;

        last_seen_d  = start_i ? 1'b0 : (last_seen_q || (push && w.last));
        word_ready_d = (free_next >= LVL_W'(WORD_BYTES)) && !last_seen_d;
        eos_d        = start_i ? 1'b0 : (eos_q || (last_seen_q && (level_next == '0)));

        byte_count_d = byte_count_q;
        overrun_d    = overrun_q;
        if (start_i) begin
            byte_count_d = '0;
            overrun_d    = '0;
        end else begin
            if (pop_real) begin
                byte_count_d = byte_count_q + CNT_W'(1);
            end
            if (eos_q && byte_req_i && (overrun_q != '1)) begin
                overrun_d = overrun_q + CNT_W'(1);
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_ready_q <= 1'b0;
            last_seen_q  <= 1'b0;
            eos_q        <= 1'b0;
            byte_count_q <= '0;
            overrun_q    <= '0;
        end else begin
            word_ready_q <= word_ready_d;
            last_seen_q  <= last_seen_d;
            eos_q        <= eos_d;
            byte_count_q <= byte_count_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_bitstream_byte_fetch.sv
// Self-checking bench for bitstream_byte_fetch: a queue-based reference of
// the byte stream checked every cycle, plus literal expectations per scenario.
module tb_bitstream_byte_fetch;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      word = '0;
    logic             word_valid = 1'b0;
    logic             word_last = 1'b0;
    logic [2:0]       nb = 3'd4;
    logic             byte_req = 1'b0;
    logic             word_ready;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic [CNT_W-1:0] byte_count;
    logic             eos;
    logic [CNT_W-1:0] overrun_count;

    always #5 clk = ~clk;

    bitstream_byte_fetch #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .word_i          (word),
        .word_valid_i    (word_valid),
        .word_last_i     (word_last),
        .word_nbytes_i   (nb),
        .word_ready_o    (word_ready),
        .byte_o          (byte_out),
        .byte_valid_o    (byte_valid),
        .byte_req_i      (byte_req),
        .byte_count_o    (byte_count),
        .eos_o           (eos),
        .overrun_count_o (overrun_count)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes waiting for the decoder, in delivery order.
    logic [7:0]       mq[$];
    bit               m_last, m_eos, m_ready;
    logic [CNT_W-1:0] m_cnt, m_ov;

    always @(posedge clk or negedge rst_n) begin
        int n;
        bit v;
        if (!rst_n) begin
            mq.delete();
            m_last = 0; m_eos = 0; m_ready = 0; m_cnt = '0; m_ov = '0;
        end else if (start) begin
            mq.delete();
            m_last = 0; m_eos = 0; m_ready = 1; m_cnt = '0; m_ov = '0;
        end else begin
            v = m_eos || (mq.size() > 0);
            if (byte_req && v) begin
                if (m_eos) begin
                    if (m_ov != '1) m_ov = m_ov + 1;
                end else begin
                    void'(mq.pop_front());
                    m_cnt = m_cnt + 1;
                end
            end
            if (word_valid && m_ready) begin
                n = (word_last && nb >= 1 && nb <= 4) ? int'(nb) : 4;
                for (int k = 0; k < n; k++) mq.push_back(word[8*(3-k) +: 8]);
                if (word_last) m_last = 1;
            end
            if (m_last && mq.size() == 0) m_eos = 1;
            m_ready = ((DEPTH - mq.size()) >= 4) && !m_last;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("word_ready", word_ready, m_ready && !start);
            chk("byte_valid", byte_valid, m_eos || (mq.size() > 0));
            chk("byte_out", byte_out, (!m_eos && mq.size() > 0) ? mq[0] : 8'h00);
            chk("byte_count", byte_count, m_cnt);
            chk("eos", eos, m_eos);
            chk("overrun_count", overrun_count, m_ov);
        end
    end

    // Capture of real-data bytes actually handed to the decoder.
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (rst_n === 1'b1 && byte_req && byte_valid && !eos && !start) got.push_back(byte_out);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n);
        int g;
        g = 0;
        word = d; word_last = l; nb = n; word_valid = 1'b1;
        @(negedge clk);
        while (word_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("word_accept_timeout", word_ready, 1);
        tick();
        word_valid = 1'b0; word_last = 1'b0; nb = 3'd4;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        @(negedge clk);
        while (byte_valid === 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_timeout", byte_valid, 0);
        tick();
    endtask

    logic [7:0] t1 [8];
    logic [7:0] ref_bytes[$];

    initial begin
        int lowready;
        int g;
        t1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset values.
        #1;
        chk("rst_word_ready", word_ready, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_count", byte_count, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: two words, no backpressure.
        pulse_start();
        got.delete();
        byte_req = 1'b1;
        send_word(32'hAABBCCDD, 0, 3'd4);
        send_word(32'h11223344, 0, 3'd4);
        wait_drain();
        chk("t1_len", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_byte", got[i], t1[i]);
        chk("t1_count", byte_count, 8);
        chk("t1_eos", eos, 0);

        // 2: words every cycle with continuous requests.
        got.delete();
        ref_bytes.delete();
        lowready = 0;
        word_valid = 1'b1; word_last = 1'b0; nb = 3'd4;
        for (int i = 0; i < 64; i++) begin
            word = $urandom;
            for (int k = 0; k < 4; k++) ref_bytes.push_back(word[8*(3-k) +: 8]);
            g = 0;
            @(negedge clk);
            while (word_ready !== 1'b1 && g < 50) begin
                lowready++;
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk("t2_accept_timeout", word_ready, 1);
            tick();
        end
        word_valid = 1'b0;
        wait_drain();
        chk("t2_throttled", lowready > 0, 1);
        chk("t2_len", got.size(), 256);
        for (int i = 0; i < 256; i++) chk("t2_byte", got[i], ref_bytes[i]);

        // 3: short last word, eos and stuffing.
        byte_req = 1'b0;
        pulse_start();
        got.delete();
        send_word(32'hDEADBEEF, 1, 3'd2);
        byte_req = 1'b1;
        g = 0;
        @(negedge clk);
        while (eos !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("t3_eos_seen", eos, 1);
        byte_req = 1'b0;
        chk("t3_len", got.size(), 2);
        chk("t3_b0", got[0], 8'hDE);
        chk("t3_b1", got[1], 8'hAD);
        tick();
        byte_req = 1'b1;
        tick(); tick(); tick();
        byte_req = 1'b0;
        @(negedge clk);
        chk("t3_overrun", overrun_count, 3);
        chk("t3_count", byte_count, 2);
        chk("t3_stuff", byte_out, 8'h00);
        tick();
        // Words refused after last.
        word = 32'h12345678; word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_refuse", word_ready, 0);
        end
        tick();
        word_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("t3_restart_count", byte_count, 0);
        chk("t3_restart_ov", overrun_count, 0);
        chk("t3_restart_eos", eos, 0);
        tick();
        send_word(32'hA1A2A3A4, 0, 3'd4);
        byte_req = 1'b1;
        wait_drain();
        chk("t3_new_count", byte_count, 4);

        // 4: request held on an empty FIFO.
        pulse_start();
        byte_req = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t4_idle_valid", byte_valid, 0);
        chk("t4_idle_count", byte_count, 0);
        tick();
        send_word(32'h01020304, 0, 3'd4);
        @(negedge clk);
        chk("t4_first_valid", byte_valid, 1);
        chk("t4_first_byte", byte_out, 8'h01);
        @(posedge clk);
        #1;
        chk("t4_first_taken", byte_count, 1);
        wait_drain();
        byte_req = 1'b0;

        // 5: asynchronous reset with 5 bytes buffered.
        pulse_start();
        send_word(32'h01020304, 0, 3'd4);
        send_word(32'h05060708, 0, 3'd4);
        byte_req = 1'b1;
        tick(); tick(); tick();
        byte_req = 1'b0;
        @(negedge clk);
        chk("t5_pre_count", byte_count, 3);
        chk("t5_pre_head", byte_out, 8'h04);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", word_ready, 0);
        chk("t5_rst_valid", byte_valid, 0);
        chk("t5_rst_byte", byte_out, 8'h00);
        chk("t5_rst_count", byte_count, 0);
        chk("t5_rst_eos", eos, 0);
        chk("t5_rst_ov", overrun_count, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        got.delete();
        byte_req = 1'b1;
        send_word(32'h0A0B0C0D, 0, 3'd4);
        wait_drain();
        chk("t5_len", got.size(), 4);
        chk("t5_b0", got[0], 8'h0A);
        chk("t5_b3", got[3], 8'h0D);
        chk("t5_count", byte_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bitstream_byte_fetch.md
Name: bitstream_byte_fetch

Overview:
- Upstream feeder for the bypass-bin / arithmetic decoder datapath. It supplies the `read_byte` operand consumed by the EP bin decoder and by the decoder's value-refill logic.
- It accepts 32-bit slice-data words from the stream interface and buffers them in a small byte FIFO.
- It serves bytes MSB-first, one per handshake, and tracks consumed-byte count and end-of-stream.
- Past end of data it stuffs 0x00, so the decoder never stalls at slice end.

Parameters:
- FIFO_DEPTH, 8, byte capacity of internal buffer; power of two, >= 8.
- CNT_W, 32, width of byte_count and overrun_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: flush FIFO, clear counters and flags, begin new slice.
- word_in  in  32  input word; byte order [31:24] first, [7:0] last.
- word_valid  in  1  word_in valid.
- word_last  in  1  qualifies the final word of the slice.
- word_nbytes  in  3  valid bytes in word_in (1..4); meaningful only with word_last, otherwise treated as 4.
- word_ready  out  1  block accepts word this cycle.
- byte_out  out  8  current head byte.
- byte_valid  out  1  byte_out is valid.
- byte_req  in  1  decoder consumes byte_out this cycle.
- byte_count  out  CNT_W  bytes delivered from real data since start.
- eos  out  1  last word received and FIFO drained.
- overrun_count  out  CNT_W  stuffed 0x00 bytes delivered after eos.

Behaviour:
- Reset (rst_n=0, async): FIFO empty; word_ready=0; byte_out=0x00; byte_valid=0; byte_count=0; eos=0; overrun_count=0; internal last_seen=0.
- start takes priority over every other event in its cycle:
  - Clears the FIFO, counters, last_seen and eos.
  - Any word or byte handshake in that cycle is ignored.
  - word_ready=0 in the start cycle; normal operation from the next cycle.
- Word accept:
  - word_ready = (free slots >= 4) && !last_seen && !start. It is registered, computed from next-state occupancy.
  - Transfer occurs when word_valid && word_ready. It pushes N bytes (N=4, or word_nbytes if word_last) in order [31:24],[23:16],...
  - word_nbytes=0 with word_last is treated as 4; word_nbytes>4 is treated as 4.
  - word_last sets last_seen; further words are refused until the next start.
- Byte output:
  - byte_out/byte_valid are registered, reflecting the FIFO head.
  - Word-to-byte latency: a byte pushed in cycle t is visible at byte_valid in cycle t+1.
  - Pop occurs when byte_req && byte_valid. The next head is presented in the following cycle with no bubble if the FIFO holds >= 2 bytes.
  - byte_req while byte_valid=0 is ignored: no pop, no count change. The decoder must hold byte_req.
- Simultaneous push and pop in one cycle are both performed. Occupancy changes by N-1.
- Counters: byte_count increments on each real-data pop. It wraps modulo 2^CNT_W with no saturation.
- End of stream:
  - eos=1 in the cycle after last_seen=1 and the FIFO becomes empty. It stays 1 until start or reset.
  - While eos=1: byte_valid=1 and byte_out=0x00.
  - Each byte_req then increments overrun_count, not byte_count. overrun_count saturates at all-ones.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap bit. Full = same index with differing wrap bits. Empty = equal pointers.
- Reset asserted mid-transfer aborts immediately. No partial word state survives.

Decomposition:
- Shared package (decoder common pkg): BYTE_W=8, WORD_BYTES=4, the stuffing byte constant 0x00, and the slice-stream word handshake struct/typedef (data, valid, last, nbytes).
- One natural sub-module: byte_fifo. It is a parameterised byte FIFO with multi-byte (up to 4) push and single pop, exposing occupancy/free count.
- The top level holds word unpacking, handshake control, counters and eos logic.

Test Plan:
- Reset then start, then push words 0xAABBCCDD and 0x11223344 with no backpressure. Required: bytes AA,BB,CC,DD,11,22,33,44 in order, byte_count=8, eos=0.
- Continuous byte_req with words arriving every cycle at FIFO_DEPTH=8. Required: word_ready drops whenever free < 4; no byte lost or duplicated over 64 words (compare against a byte-reference queue).
- Last word 0xDEADBEEF with word_last=1, word_nbytes=2. Required: only DE,AD are delivered; eos=1 the cycle after the FIFO drains; the next 3 byte_req return 0x00; overrun_count=3 and byte_count unchanged.
- After last_seen, assert word_valid with 0x12345678. Required: word_ready=0 and nothing pushed. Then pulse start. Required: counters=0, eos=0, and new words are accepted.
- Hold byte_req=1 with the FIFO empty and no last. Required: byte_valid=0 and byte_count unchanged. Then push 0x01020304. Required: byte 01 is valid the next cycle and consumed the same cycle.
- Drop rst_n asynchronously mid-stream (FIFO holding 5 bytes). Required: all outputs take reset values without a clock edge; after release plus start, the stream restarts cleanly.
